// File: rtl/pe_share_arbiter_pkg.sv
// Shared definitions for the packet-granular MAC arbiter.
//   DATA_BITS_DEF : default width of data, weight, accumulator and result
//   LEN_BITS_DEF  : default width of the per-packet beat counter
//   state_e       : arbiter FSM encoding
package pe_share_arbiter_pkg;

    localparam int DATA_BITS_DEF = 16;
    localparam int LEN_BITS_DEF  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: sum = acc + data*wgt, wrapped to DATA_BITS.
//   acc  : running accumulator
//   data : input operand (signed two's complement)
//   wgt  : weight operand (signed two's complement)
//   sum  : low DATA_BITS of acc + data*wgt
module pe_mac #(
    parameter int DATA_BITS = 16
) (
    input  logic [DATA_BITS-1:0] acc,
    input  logic [DATA_BITS-1:0] data,
    input  logic [DATA_BITS-1:0] wgt,
    output logic [DATA_BITS-1:0] sum
);

    // Only the low DATA_BITS of the product survive the wrap, so the
    // product is computed at that width directly.
    logic signed [DATA_BITS-1:0] prod;

    assign prod = $signed(data) * $signed(wgt);
    assign sum  = acc + prod;

endmodule

// File: rtl/pe_share_arbiter.sv
// Two requesters share one MAC datapath; arbitration is per packet with a
// round-robin pointer. Each packet's dot product is delivered through a
// single result register with valid/ready handshake.
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   reqN_valid/ready    : beat handshake for requester N
//   reqN_data/wgt/last  : beat operands and end-of-packet marker
//   res_valid/ready     : result handshake
//   res_data/id/len     : dot product, producing requester, saturated beat count
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant; readies low; pick requester on any valid
// ST_BUSY | grant held by grant_q until its last beat is accepted
module pe_share_arbiter
    import pe_share_arbiter_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LEN_BITS  = LEN_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_BITS-1:0] req0_data,
    input  logic [DATA_BITS-1:0] req0_wgt,
    input  logic                 req0_last,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_BITS-1:0] req1_data,
    input  logic [DATA_BITS-1:0] req1_wgt,
    input  logic                 req1_last,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_BITS-1:0] res_data,
    output logic                 res_id,
    output logic [LEN_BITS-1:0]  res_len
);

    state_e                state_q;
    logic                  grant_q;
    logic                  ptr_q;
    logic [DATA_BITS-1:0]  acc_q;
    logic [LEN_BITS-1:0]   cnt_q;
    logic                  res_valid_q;
    logic [DATA_BITS-1:0]  res_data_q;
    logic                  res_id_q;
    logic [LEN_BITS-1:0]   res_len_q;

    logic                  busy;
    logic                  stall;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_BITS-1:0]  sel_data;
    logic [DATA_BITS-1:0]  sel_wgt;
    logic                  accept;
    logic                  grant_d;
    logic [DATA_BITS-1:0]  mac_sum;
    logic [LEN_BITS-1:0]   cnt_inc;

    assign busy  = (state_q == ST_BUSY);
    // Hold off beats only while an unread result would otherwise be
    // overwritten; a result being read this cycle frees the register.
    assign stall = res_valid_q & ~res_ready;

    assign req0_ready = busy & ~grant_q & ~stall;
    assign req1_ready = busy &  grant_q & ~stall;

    assign sel_valid = grant_q ? req1_valid : req0_valid;
    assign sel_last  = grant_q ? req1_last  : req0_last;
    assign sel_data  = grant_q ? req1_data  : req0_data;
    assign sel_wgt   = grant_q ? req1_wgt   : req0_wgt;
    assign accept    = busy & ~stall & sel_valid;

    // Pointer only matters on a tie; otherwise the lone requester wins.
    assign grant_d = (req0_valid & req1_valid) ? ptr_q : req1_valid;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + LEN_BITS'(1);

    pe_mac #(
        .DATA_BITS (DATA_BITS)
    ) u_mac (
        .acc  (acc_q),
        .data (sel_data),
        .wgt  (sel_wgt),
        .sum  (mac_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            ptr_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_len_q   <= '0;
        end else begin
            if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant_q <= grant_d;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept) begin
                        if (sel_last) begin
                            // Later assignment overrides the read-clear above.
                            res_valid_q <= 1'b1;
                            res_data_q  <= mac_sum;
                            res_len_q   <= cnt_inc;
                            res_id_q    <= grant_q;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            ptr_q       <= ~grant_q;
                            state_q     <= ST_IDLE;
                        end else begin
                            acc_q <= mac_sum;
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_len   = res_len_q;

endmodule

// File: tb/tb_pe_share_arbiter.sv
module tb_pe_share_arbiter;

    logic        clk;
    logic        rst;

    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_data, req1_data, req0_wgt, req1_wgt;
    logic        req0_last, req1_last;
    logic        res_valid, res_ready, res_id;
    logic [15:0] res_data;
    logic [7:0]  res_len;

    logic        s_req0_valid, s_req0_ready, s_req1_ready;
    logic [15:0] s_req0_data, s_req0_wgt;
    logic        s_req0_last;
    logic        s_res_valid, s_res_ready, s_res_id;
    logic [15:0] s_res_data;
    logic [1:0]  s_res_len;

    int tests_run;
    int tests_failed;

    pe_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_wgt   (req0_wgt),
        .req0_last  (req0_last),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_wgt   (req1_wgt),
        .req1_last  (req1_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_len    (res_len)
    );

    pe_share_arbiter #(.DATA_BITS(16), .LEN_BITS(2)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (s_req0_valid),
        .req0_ready (s_req0_ready),
        .req0_data  (s_req0_data),
        .req0_wgt   (s_req0_wgt),
        .req0_last  (s_req0_last),
        .req1_valid (1'b0),
        .req1_ready (s_req1_ready),
        .req1_data  (16'd0),
        .req1_wgt   (16'd0),
        .req1_last  (1'b0),
        .res_valid  (s_res_valid),
        .res_ready  (s_res_ready),
        .res_data   (s_res_data),
        .res_id     (s_res_id),
        .res_len    (s_res_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        req0_valid = 0; req0_data = 0; req0_wgt = 0; req0_last = 0;
        req1_valid = 0; req1_data = 0; req1_wgt = 0; req1_last = 0;
        res_ready  = 0;
        s_req0_valid = 0; s_req0_data = 0; s_req0_wgt = 0; s_req0_last = 0;
        s_res_ready  = 0;

        // reset state
        #12;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_len",   32'(res_len),   32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_rdy0",      32'(req0_ready), 32'd0);
        chk("rst_rdy1",      32'(req1_ready), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_no_grant", 32'(req0_ready), 32'd0);

        // single beat 3*4
        res_ready = 1; req0_valid = 1; req0_data = 16'd3; req0_wgt = 16'd4; req0_last = 1;
        tick();
        chk("sb_rdy0", 32'(req0_ready), 32'd1);
        chk("sb_noval_yet", 32'(res_valid), 32'd0);
        tick();
        req0_valid = 0;
        chk("sb_valid", 32'(res_valid), 32'd1);
        chk("sb_data",  32'(res_data),  32'd12);
        chk("sb_id",    32'(res_id),    32'd0);
        chk("sb_len",   32'(res_len),   32'd1);
        chk("sb_idle_rdy0", 32'(req0_ready), 32'd0);
        tick();
        chk("sb_consumed", 32'(res_valid), 32'd0);

        // both valid from reset: req0 (1*2, 3*4) then req1 (5*5)
        pulse_reset();
        req0_valid = 1; req0_data = 16'd1; req0_wgt = 16'd2; req0_last = 0;
        req1_valid = 1; req1_data = 16'd5; req1_wgt = 16'd5; req1_last = 1;
        tick();
        chk("rr_rdy0", 32'(req0_ready), 32'd1);
        chk("rr_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_data = 16'd3; req0_wgt = 16'd4; req0_last = 1;
        chk("rr_rdy1_mid", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 0;
        chk("rr_r0_valid", 32'(res_valid), 32'd1);
        chk("rr_r0_data",  32'(res_data),  32'd14);
        chk("rr_r0_id",    32'(res_id),    32'd0);
        chk("rr_r0_len",   32'(res_len),   32'd2);
        tick();
        chk("rr_rdy1_grant", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 0;
        chk("rr_r1_data", 32'(res_data), 32'd25);
        chk("rr_r1_id",   32'(res_id),   32'd1);
        chk("rr_r1_len",  32'(res_len),  32'd1);

        // back-pressure: result 7 from req0 held while req1 granted
        pulse_reset();
        res_ready = 0;
        req0_valid = 1; req0_data = 16'd7; req0_wgt = 16'd1; req0_last = 1;
        req1_valid = 1; req1_data = 16'd6; req1_wgt = 16'd1; req1_last = 1;
        tick();
        tick();
        req0_valid = 0;
        chk("bp_first_data", 32'(res_data), 32'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_rdy1_stall", 32'(req1_ready), 32'd0);
            chk("bp_hold_valid", 32'(res_valid),  32'd1);
            chk("bp_hold_data",  32'(res_data),   32'd7);
            chk("bp_hold_id",    32'(res_id),     32'd0);
        end
        res_ready = 1;
        #1;
        chk("bp_rdy1_release", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 0;
        chk("bp_new_valid", 32'(res_valid), 32'd1);
        chk("bp_new_data",  32'(res_data),  32'd6);
        chk("bp_new_id",    32'(res_id),    32'd1);
        tick();
        chk("bp_drained", 32'(res_valid), 32'd0);

        // wrap: 0x7FFF*1 + 1*1, then signed -2*3
        pulse_reset();
        req0_valid = 1; req0_data = 16'h7FFF; req0_wgt = 16'd1; req0_last = 0;
        tick();
        tick();
        req0_data = 16'd1; req0_wgt = 16'd1; req0_last = 1;
        tick();
        req0_data = 16'hFFFE; req0_wgt = 16'd3; req0_last = 1;
        chk("wrap_data", 32'(res_data), 32'h8000);
        chk("wrap_len",  32'(res_len),  32'd2);
        tick();
        tick();
        req0_valid = 0;
        chk("neg_data", 32'(res_data), 32'hFFFA);
        chk("neg_len",  32'(res_len),  32'd1);

        // reset mid-packet after an earlier result 9 sits in res_data
        pulse_reset();
        req0_valid = 1; req0_data = 16'd9; req0_wgt = 16'd1; req0_last = 1;
        tick();
        tick();
        req0_data = 16'd1; req0_wgt = 16'd1; req0_last = 0;
        chk("mr_pre_data", 32'(res_data), 32'd9);
        tick();
        tick();
        tick();
        chk("mr_busy_rdy0", 32'(req0_ready), 32'd1);
        rst = 1'b0;
        #1;
        chk("mr_res_valid", 32'(res_valid),  32'd0);
        chk("mr_rdy0",      32'(req0_ready), 32'd0);
        chk("mr_rdy1",      32'(req1_ready), 32'd0);
        chk("mr_res_data",  32'(res_data),   32'd0);
        chk("mr_res_len",   32'(res_len),    32'd0);
        req0_valid = 0;
        #2;
        rst = 1'b1;
        req0_valid = 1; req0_data = 16'd2; req0_wgt = 16'd2; req0_last = 1;
        tick();
        tick();
        req0_valid = 0;
        chk("mr_after_data", 32'(res_data), 32'd4);
        chk("mr_after_len",  32'(res_len),  32'd1);

        // length saturation on the LEN_BITS=2 instance
        s_res_ready = 1;
        s_req0_valid = 1; s_req0_data = 16'd1; s_req0_wgt = 16'd1; s_req0_last = 0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        s_req0_last = 1;
        tick();
        s_req0_valid = 0;
        chk("sat_valid", 32'(s_res_valid),  32'd1);
        chk("sat_len",   32'(s_res_len),    32'd3);
        chk("sat_data",  32'(s_res_data),   32'd5);
        chk("sat_id",    32'(s_res_id),     32'd0);
        chk("sat_rdy1",  32'(s_req1_ready), 32'd0);
        chk("sat_rdy0",  32'(s_req0_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pe_share_arbiter.md
PE_SHARE_ARBITER -- requirements
Module: pe_share_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 16: width of data, weight, accumulator and result.
REQ-002 Parameter LEN_BITS, default 8: width of the beat counter reported with each result.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset; asynchronous, active-low.
REQ-005 req0_valid, req1_valid  input  1 each: requester r presents a beat.
REQ-006 req0_ready, req1_ready  output  1 each: beat from requester r is accepted when valid and ready are both high.
REQ-007 req0_data, req1_data  input  DATA_BITS each: input operand.
REQ-008 req0_wgt, req1_wgt  input  DATA_BITS each: weight operand.
REQ-009 req0_last, req1_last  input  1 each: marks the final beat of a packet.
REQ-010 res_valid  output  1: result register holds an unread result.
REQ-011 res_ready  input  1: consumer accepts the result.
REQ-012 res_data  output  DATA_BITS: accumulated dot product of the packet.
REQ-013 res_id  output  1: requester that produced the result.
REQ-014 res_len  output  LEN_BITS: number of beats in the packet, saturating.

Function
REQ-015 The block SHALL share one multiply-accumulate datapath between two requesters, with arbitration at packet granularity.
REQ-016 The state machine SHALL have exactly two states: IDLE and BUSY.
REQ-017 In IDLE, both req ready outputs SHALL be 0.
- If any reqN_valid is 1, grant is registered and the next state is BUSY.
- If both are valid, the requester selected by the round-robin pointer wins.
- The pointer resets to 0.
REQ-018 In BUSY, reqG_ready SHALL equal NOT(res_valid AND NOT res_ready) for the granted requester G; the other ready SHALL be 0.
REQ-019 On each accepted beat, acc SHALL become acc + data*wgt.
- The product is signed two's complement.
- The sum is truncated (wrap-around) to the low DATA_BITS bits.
- There is no saturation.
REQ-020 On each accepted beat, the beat counter SHALL increment and saturate at 2^LEN_BITS-1.
REQ-021 On an accepted beat with last=1, all of the following SHALL occur in the same cycle:
- res_data is loaded with acc + data*wgt.
- res_len is loaded with the count including this beat.
- res_id is loaded with G and res_valid is set.
- acc and the beat counter are cleared.
- The pointer is set to the requester other than G.
- The next state is IDLE.
REQ-022 Latency: an accepted last beat in cycle N SHALL make res_valid=1 in cycle N+1.
REQ-023 res_valid SHALL clear on a cycle with res_valid AND res_ready unless a new result loads in the same cycle.
- A new result can load in that same cycle only because REQ-018 allows ready while res_ready=1.
- If a new result loads, the new result replaces the old one and res_valid stays 1.
REQ-024 A result SHALL never be overwritten while res_valid=1 and res_ready=0; the stall in REQ-018 guarantees this.
REQ-025 Beats with valid=1 and ready=0 SHALL leave acc, the counter and state unchanged.
- Requesters SHALL hold data stable until accepted; the block does not check this.
REQ-026 The non-granted requester's valid SHALL be ignored until the current packet completes, regardless of its duration.
REQ-027 A single-beat packet (last=1 on the first beat) SHALL yield res_len=1 and res_data=data*wgt.
REQ-028 A requester SHALL lose no more than one packet to the other when both are continuously valid; strict alternation follows from REQ-021.

Reset
REQ-029 Asserting rst SHALL immediately force all of the following, discarding any partial packet and any unread result:
- state=IDLE and pointer=0.
- acc=0 and counter=0.
- res_valid=0, res_data=0, res_id=0, res_len=0.
- req0_ready=0 and req1_ready=0.
REQ-030 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge at which a valid is sampled.

Structure
REQ-031 The shared package SHALL hold the DATA_BITS and LEN_BITS defaults and the IDLE/BUSY state encoding.
REQ-032 The multiply-accumulate SHALL be a sub-module named pe_mac.
- Inputs: acc, data, wgt.
- Output: the wrapped sum.
- Purely combinational.
- The arbiter owns all registers.

Verification
REQ-033 Single beat: after reset, req0 sends data=3, wgt=4, last=1 with res_ready=1.
- Required: res_valid one cycle after acceptance.
- Required: res_data=12, res_id=0, res_len=1.
REQ-034 Both requesters valid from reset; req0 sends 2 beats (1*2, 3*4) and req1 sends 1 beat (5*5).
- Required: req0 is served first with res_data=14, res_len=2.
- Required: req1 is served next with res_data=25, res_id=1.
REQ-035 Back-pressure: hold res_ready=0 after the first result while req1 is granted.
- Required: req1_ready=0 throughout.
- Required: the first result stays stable.
- Required: after res_ready=1, req1 is accepted and no result is lost.
REQ-036 Wrap and sign: req0 sends 0x7FFF*1 then 1*1, last.
- Required: res_data=0x8000.
- Also required: -2*3 gives 0xFFFA.
REQ-037 Reset mid-packet: req0 sends 2 of 4 beats, then rst pulses low.
- Required: res_valid=0 and both readies 0 immediately.
- Required: a subsequent 1-beat packet 2*2 gives res_data=4, res_len=1.
REQ-038 Saturation: with LEN_BITS=2, a 5-beat packet of 1*1.
- Required: res_len=3, res_data=5.
